sram_access_ctrl: RTL and testbench

Sequencing controller for the MEM stage: takes the memory read/write request held in the EXE→MEM pipeline register and performs it on a 16-bit external SRAM as two halfword phases with programmable wait states. While an access is in flight it holds `ready` low. The pipeline uses `~ready` as the freeze input to the pipeline registers, so every stage holds its contents until the 32-bit word has been transferred.

---
 rtl/sram_access_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: MEM-stage sequencer that transfers one 32-bit word to or
// from a 16-bit external SRAM as two halfword phases (low, then high), each
// lasting WAIT_CYCLES+1 cycles. 'ready' stays low while an access is in flight
// so the pipeline freezes until the word has moved.
// Optional build macro: SRAM_ADDR_CHECK_EN adds the 'addrErr' output and
// rejects misaligned or out-of-window addresses without strobing the SRAM.
module sram_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] sramAddr,
  input  logic [15:0] sramDIn,
  output logic [15:0] sramDOut,
  output logic        sramDOE,
  output logic        sramWEn_N
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic        addrErr
`endif
);

  // The wait counter must be able to hold WAIT_CYCLES; keep at least one bit
  // so a zero-wait build still has a legal vector.
  localparam int unsigned     CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [31:0]      BASE     = 32'(ADDR_BASE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             isWrite_q, isWrite_d;
  logic [31:0]      readData_q, readData_d;
  logic [17:0]      sramAddr_q, sramAddr_d;
  logic [15:0]      sramDOut_q, sramDOut_d;
  logic             sramDOE_q, sramDOE_d;
  logic             sramWEn_N_q, sramWEn_N_d;

  logic [31:0]      offset;
  logic             reqValid;
  logic             reqErr;
  logic             phaseLast;
  logic             unusedOffsetBits;

  // Byte offset into the SRAM window; halfword address is offset[18:1],
  // and the word's two halfwords differ only in bit 0.
  assign offset    = address - BASE;
  assign reqValid  = wrEn | rdEn;
  assign phaseLast = (cnt_q == CNT_LAST);

`ifdef SRAM_ADDR_CHECK_EN
  logic addrErr_q, addrErr_d;

  // A request is rejected if it lies below the window, is not word aligned,
  // or reaches past the 512 KiB the 18-bit halfword address can cover.
  assign reqErr = (address < BASE) || (address[1:0] != 2'b00) || (offset[31:19] != 13'd0);
  assign unusedOffsetBits = ^offset[1:0];
  assign addrErr = addrErr_q;
`else
  // Without checking, addresses simply wrap inside the SRAM window.
  assign reqErr = 1'b0;
  assign unusedOffsetBits = ^{offset[31:19], offset[1:0]};
`endif

  // The pipeline may advance when nothing is requested, or for the single
  // DONE cycle that completes the access.
  assign ready = ((state_q == IDLE) && !reqValid) || (state_q == DONE);

  assign readData  = readData_q;
  assign sramAddr  = sramAddr_q;
  assign sramDOut  = sramDOut_q;
  assign sramDOE   = sramDOE_q;
  assign sramWEn_N = sramWEn_N_q;

  // State register and registered SRAM-side outputs; reset drops the strobe
  // and bus enable immediately, abandoning any access in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      isWrite_q   <= 1'b0;
      readData_q  <= 32'd0;
      sramAddr_q  <= 18'd0;
      sramDOut_q  <= 16'd0;
      sramDOE_q   <= 1'b0;
      sramWEn_N_q <= 1'b1;
`ifdef SRAM_ADDR_CHECK_EN
      addrErr_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      isWrite_q   <= isWrite_d;
      readData_q  <= readData_d;
      sramAddr_q  <= sramAddr_d;
      sramDOut_q  <= sramDOut_d;
      sramDOE_q   <= sramDOE_d;
      sramWEn_N_q <= sramWEn_N_d;
`ifdef SRAM_ADDR_CHECK_EN
      addrErr_q   <= addrErr_d;
`endif
    end
  end

  // Next-state logic: IDLE samples the request, LOW and HIGH each run one
  // halfword phase, DONE is a one-cycle release so the still-present request
  // is not reissued.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    isWrite_d   = isWrite_q;
    readData_d  = readData_q;
    sramAddr_d  = sramAddr_q;
    sramDOut_d  = sramDOut_q;
    sramDOE_d   = sramDOE_q;
    sramWEn_N_d = sramWEn_N_q;
`ifdef SRAM_ADDR_CHECK_EN
    addrErr_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (reqValid) begin
          cnt_d     = '0;
          isWrite_d = wrEn;
          if (reqErr) begin
            state_d    = DONE;
            readData_d = 32'd0;
`ifdef SRAM_ADDR_CHECK_EN
            addrErr_d  = 1'b1;
`endif
          end else begin
            state_d    = LOW;
            sramAddr_d = {offset[18:2], 1'b0};
            if (wrEn) begin
              sramDOut_d  = writeData[15:0];
              sramDOE_d   = 1'b1;
              sramWEn_N_d = 1'b0;
            end else begin
              sramDOE_d   = 1'b0;
              sramWEn_N_d = 1'b1;
            end
          end
        end
      end

      LOW: begin
        if (phaseLast) begin
          cnt_d      = '0;
          state_d    = HIGH;
          sramAddr_d = {sramAddr_q[17:1], 1'b1};
          if (isWrite_q) begin
            sramDOut_d = writeData[31:16];
          end else begin
            readData_d[15:0] = sramDIn;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HIGH: begin
        if (phaseLast) begin
          cnt_d       = '0;
          state_d     = DONE;
          sramDOE_d   = 1'b0;
          sramWEn_N_d = 1'b1;
          if (!isWrite_q) begin
            readData_d[31:16] = sramDIn;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: directed bench for sram_access_ctrl with a small
// behavioural SRAM; a second zero-wait instance covers the shortest phase.
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEn;
  logic        rdEn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] sramAddr;
  logic [15:0] sramDIn;
  logic [15:0] sramDOut;
  logic        sramDOE;
  logic        sramWEn_N;

  logic        rdEn0;
  logic [31:0] readData0;
  logic        ready0;
  logic [17:0] sramAddr0;
  logic [15:0] sramDIn0;
  logic [15:0] unusedDOut0;
  logic        unusedDOE0;
  logic        unusedWEn0;
  logic        unusedAddrHi0;

`ifdef SRAM_ADDR_CHECK_EN
  logic        addrErr;
  logic        unusedAddrErr0;
`endif

  logic [15:0] sramMem [0:7];

  int checks   = 0;
  int failures = 0;

  sram_access_ctrl #(.WAIT_CYCLES(2), .ADDR_BASE(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .wrEn      (wrEn),
    .rdEn      (rdEn),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .ready     (ready),
    .sramAddr  (sramAddr),
    .sramDIn   (sramDIn),
    .sramDOut  (sramDOut),
    .sramDOE   (sramDOE),
    .sramWEn_N (sramWEn_N)
`ifdef SRAM_ADDR_CHECK_EN
    ,
    .addrErr   (addrErr)
`endif
  );

  sram_access_ctrl #(.WAIT_CYCLES(0), .ADDR_BASE(1024)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .wrEn      (1'b0),
    .rdEn      (rdEn0),
    .address   (address),
    .writeData (writeData),
    .readData  (readData0),
    .ready     (ready0),
    .sramAddr  (sramAddr0),
    .sramDIn   (sramDIn0),
    .sramDOut  (unusedDOut0),
    .sramDOE   (unusedDOE0),
    .sramWEn_N (unusedWEn0)
`ifdef SRAM_ADDR_CHECK_EN
    ,
    .addrErr   (unusedAddrErr0)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SRAM for the main instance: asynchronous read, write while strobe low
  assign sramDIn = sramMem[sramAddr[2:0]];
  always @(posedge clk) begin
    if (!sramWEn_N) sramMem[sramAddr[2:0]] <= sramDOut;
  end

  // Zero-wait instance reads a recognisable pattern derived from its address
  assign sramDIn0      = 16'h1000 + sramAddr0[15:0];
  assign unusedAddrHi0 = ^sramAddr0[17:16];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] data);
    wrEn      = wr;
    rdEn      = rd;
    address   = addr;
    writeData = data;
  endtask

  // Safety net so the run always terminates
  initial begin
    #20000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    rst   = 1'b1;
    rdEn0 = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 8; i++) sramMem[i] = 16'h0000;
    sramMem[4] = 16'h5678;
    sramMem[5] = 16'h1234;

    // Reset with no request
    #2 rst = 1'b0;
    #2;
    checkOutput("rst_ready",    32'(ready),     32'd1);
    checkOutput("rst_wen_n",    32'(sramWEn_N), 32'd1);
    checkOutput("rst_doe",      32'(sramDOE),   32'd0);
    checkOutput("rst_readdata", readData,       32'd0);
    checkOutput("rst_addr",     32'(sramAddr),  32'd0);
    checkOutput("rst_dout",     32'(sramDOut),  32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Write 0xDEADBEEF to byte address 1028 (halfwords 2 and 3)
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput("wr_ready", 32'(ready),     32'(c == 8));
      checkOutput("wr_wen_n", 32'(sramWEn_N), 32'((c < 2) || (c > 7)));
      checkOutput("wr_doe",   32'(sramDOE),   32'((c >= 2) && (c <= 7)));
      if ((c >= 2) && (c <= 7)) begin
        checkOutput("wr_addr", 32'(sramAddr), (c <= 4) ? 32'd2 : 32'd3);
        checkOutput("wr_dout", 32'(sramDOut), (c <= 4) ? 32'h0000BEEF : 32'h0000DEAD);
      end
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("wr_idle_ready",    32'(ready), 32'd1);
    checkOutput("wr_keeps_readdata", readData,  32'd0);
    @(posedge clk); #1;

    // Read the word back from 1028
    applyStimulus(1'b0, 1'b1, 32'd1028, 32'd0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput("rd_ready", 32'(ready),     32'(c == 8));
      checkOutput("rd_wen_n", 32'(sramWEn_N), 32'd1);
      checkOutput("rd_doe",   32'(sramDOE),   32'd0);
      if (c == 5) checkOutput("rd_low_half", readData, 32'h0000BEEF);
      if (c == 8) checkOutput("rd_word",     readData, 32'hDEADBEEF);
      @(posedge clk); #1;
    end

    // Write and read together at 1032: the write wins and readData is untouched
    applyStimulus(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput("both_ready", 32'(ready),     32'(c == 8));
      checkOutput("both_wen_n", 32'(sramWEn_N), 32'((c < 2) || (c > 7)));
      if ((c == 5) || (c == 8)) checkOutput("both_readdata", readData, 32'hDEADBEEF);
      @(posedge clk); #1;
    end

    // Back-to-back read of 1032, starting in the cycle right after DONE
    applyStimulus(1'b0, 1'b1, 32'd1032, 32'd0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput("b2b_ready", 32'(ready), 32'(c == 8));
      if (c == 8) checkOutput("b2b_word", readData, 32'hCAFEF00D);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;

`ifdef SRAM_ADDR_CHECK_EN
    // Rejected requests: below base, misaligned, beyond the window
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, (k == 0) ? 32'd1000 : ((k == 1) ? 32'd1030 : 32'h0008_0400), 32'd0);
      @(negedge clk);
      checkOutput("err_c1_ready",   32'(ready),   32'd0);
      checkOutput("err_c1_addrerr", 32'(addrErr), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("err_c2_ready",    32'(ready),     32'd1);
      checkOutput("err_c2_addrerr",  32'(addrErr),   32'd1);
      checkOutput("err_c2_readdata", readData,       32'd0);
      checkOutput("err_c2_wen_n",    32'(sramWEn_N), 32'd1);
      checkOutput("err_c2_doe",      32'(sramDOE),   32'd0);
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("err_c3_addrerr", 32'(addrErr), 32'd0);
      checkOutput("err_c3_ready",   32'(ready),   32'd1);
      @(posedge clk); #1;
    end
`else
    // Address below base wraps: offset 0xFFFFFFE8 maps to halfwords 0x3FFF4/5
    applyStimulus(1'b0, 1'b1, 32'd1000, 32'd0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput("wrap_ready", 32'(ready), 32'(c == 8));
      if (c == 2) checkOutput("wrap_addr_lo", 32'(sramAddr), 32'h0003FFF4);
      if (c == 5) checkOutput("wrap_addr_hi", 32'(sramAddr), 32'h0003FFF5);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
`endif

    // Reset in the middle of the HIGH phase of a write to 1036
    applyStimulus(1'b1, 1'b0, 32'd1036, 32'h11112222);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_pre_wen_n", 32'(sramWEn_N), 32'd0);
    checkOutput("abort_pre_addr",  32'(sramAddr),  32'd7);
    checkOutput("abort_pre_dout",  32'(sramDOut),  32'h00001111);
    #1 rst = 1'b0;
    #1;
    checkOutput("abort_wen_n",    32'(sramWEn_N), 32'd1);
    checkOutput("abort_doe",      32'(sramDOE),   32'd0);
    checkOutput("abort_ready",    32'(ready),     32'd0);
    checkOutput("abort_readdata", readData,       32'd0);
    checkOutput("abort_addr",     32'(sramAddr),  32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("abort_noreq_ready", 32'(ready), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(ready),     32'd1);
    checkOutput("post_rst_wen_n", 32'(sramWEn_N), 32'd1);
    @(posedge clk); #1;

    // Zero-wait instance: one-cycle phases, ready low for three cycles
    address = 32'd1028;
    rdEn0   = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput("w0_ready", 32'(ready0), 32'(c == 4));
      if (c == 3) checkOutput("w0_low_half", readData0, 32'h00001002);
      if (c == 4) checkOutput("w0_word",     readData0, 32'h10031002);
      @(posedge clk); #1;
    end
    rdEn0 = 1'b0;
    @(negedge clk);
    checkOutput("w0_idle_ready", 32'(ready0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
